// File: rtl/pkt_arb2_pkg.sv
// Shared encodings for the two-input packet arbiter and the downstream 2:1 mux.
package pkt_arb2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_A = 2'd1,
        ST_GNT_B = 2'd2
    } arb_state_e;

    // Mux select convention: y = sel ? a : b
    localparam logic SEL_A = 1'b1;
    localparam logic SEL_B = 1'b0;

    function automatic arb_state_e grant_of(input logic pick_a);
        return pick_a ? ST_GNT_A : ST_GNT_B;
    endfunction

    function automatic logic sel_of(input logic pick_a);
        return pick_a ? SEL_A : SEL_B;
    endfunction

endpackage

// File: rtl/pkt_arb2_out_reg.sv
// One-deep valid/ready output register: a fire loads a new beat (replacing any
// beat being drained in the same cycle), otherwise an accepted beat empties it.
module pkt_arb2_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             last_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             last_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;

    // Load on fire, otherwise drop valid once the consumer takes the beat; data holds after drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
        end else if (ready_i && valid_q) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;

endmodule

// File: rtl/pkt_arb2.sv
// Two-input packet-level round-robin arbiter. The grant is held for a whole
// packet; the winner streams through a one-deep output register.
//
// state    | meaning
// ---------+------------------------------------------
// ST_IDLE  | no owner, arbitrate on the next valid
// ST_GNT_A | A owns the output until its last beat
// ST_GNT_B | B owns the output until its last beat
module pkt_arb2
    import pkt_arb2_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    input  logic             b_valid,
    output logic             b_ready,
    output logic             sel,
    output logic [WIDTH-1:0] y_data,
    output logic             y_last,
    output logic             y_valid,
    input  logic             y_ready
);

    arb_state_e       state_q;
    logic             prio_a_q;
    logic             sel_q;

    logic             load;
    logic             fire_a;
    logic             fire_b;
    logic             pick_a;
    logic [WIDTH-1:0] in_data;
    logic             in_last;

    assign load    = ~y_valid | y_ready;
    assign a_ready = load & (state_q == ST_GNT_A);
    assign b_ready = load & (state_q == ST_GNT_B);
    assign fire_a  = a_valid & a_ready;
    assign fire_b  = b_valid & b_ready;

    // Tie goes to whichever input the priority flag currently favours.
    assign pick_a  = a_valid & (prio_a_q | ~b_valid);

    // Only one fire can be live, so a plain 2:1 pick is enough.
    assign in_data = fire_a ? a_data : b_data;
    assign in_last = fire_a ? a_last : b_last;

    // Grant FSM, priority flag and mux select; switch at end of packet without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            prio_a_q <= 1'b1;
            sel_q    <= SEL_B;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (a_valid || b_valid) begin
                        state_q <= grant_of(pick_a);
                        sel_q   <= sel_of(pick_a);
                    end
                end
                ST_GNT_A: begin
                    if (fire_a && a_last) begin
                        prio_a_q <= 1'b0;
                        if (b_valid) begin
                            state_q <= ST_GNT_B;
                            sel_q   <= SEL_B;
                        end else if (a_valid) begin
                            state_q <= ST_GNT_A;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_GNT_B: begin
                    if (fire_b && b_last) begin
                        prio_a_q <= 1'b1;
                        if (a_valid) begin
                            state_q <= ST_GNT_A;
                            sel_q   <= SEL_A;
                        end else if (b_valid) begin
                            state_q <= ST_GNT_B;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sel = sel_q;

    pkt_arb2_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (fire_a | fire_b),
        .data_i  (in_data),
        .last_i  (in_last),
        .ready_i (y_ready),
        .valid_o (y_valid),
        .data_o  (y_data),
        .last_o  (y_last)
    );

endmodule
